// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional stall/flush performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter int unsigned bit_size  = 32,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PC_write,
  input  logic                IFID_write,
  input  logic                IF_Flush,
  input  logic [1:0]          EX_JumpOP,
  input  logic [bit_size-1:0] EX_Jump_target,
  input  logic [bit_size-1:0] IM_instr,
  output logic [bit_size-1:0] IM_addr,
  output logic [bit_size-1:0] ID_Instr,
  output logic [bit_size-1:0] ID_PC,
  output logic [bit_size-1:0] ID_PC_plus4,
  output logic                ID_Valid,
  output logic [15:0]         IF_stall_cnt,
  output logic [15:0]         IF_flush_cnt
);

  localparam logic [bit_size-1:0] Four = bit_size'(4);

  logic [bit_size-1:0] pc_q, pc_d;
  logic [bit_size-1:0] pc_plus4;
  logic [bit_size-1:0] id_instr_q, id_instr_d;
  logic [bit_size-1:0] id_pc_q, id_pc_d;
  logic [bit_size-1:0] id_pc_plus4_q, id_pc_plus4_d;
  logic                id_valid_q, id_valid_d;

  // Modulo add: the top word address wraps to zero.
  assign pc_plus4 = pc_q + Four;
  assign IM_addr  = pc_q;

  // Flush outranks a stall so a redirect is never lost behind a hazard hold.
  always_comb begin
    pc_d = pc_plus4;
    if (IF_Flush) begin
      if (EX_JumpOP != 2'd0) begin
        pc_d = {EX_Jump_target[bit_size-1:2], 2'b00};
      end
    end else if (PC_write) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    if (IF_Flush) begin
      id_instr_d    = NOP_INSTR[bit_size-1:0];
      id_pc_d       = '0;
      id_pc_plus4_d = '0;
      id_valid_d    = 1'b0;
    end else if (!IFID_write) begin
      id_instr_d    = IM_instr;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC[bit_size-1:0];
      id_instr_q    <= NOP_INSTR[bit_size-1:0];
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign ID_Instr    = id_instr_q;
  assign ID_PC       = id_pc_q;
  assign ID_PC_plus4 = id_pc_plus4_q;
  assign ID_Valid    = id_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; a stall cycle that is overridden by a flush is not counted as a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PC_write && !IF_Flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (IF_Flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign IF_stall_cnt = stall_cnt_q;
  assign IF_flush_cnt = flush_cnt_q;
`else
  assign IF_stall_cnt = 16'h0;
  assign IF_flush_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, jump, flush+stall, wrap, counters.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_write, IFID_write, IF_Flush;
  logic [1:0]  EX_JumpOP;
  logic [31:0] EX_Jump_target;
  logic [31:0] IM_instr, IM_addr;
  logic [31:0] ID_Instr, ID_PC, ID_PC_plus4;
  logic        ID_Valid;
  logic [15:0] IF_stall_cnt, IF_flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory: a fixed word at 0, elsewhere a tag derived from the address.
  assign IM_instr = (IM_addr == 32'h0) ? 32'h2001_0005 : (32'hC000_0000 | IM_addr);

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PC_write      (PC_write),
    .IFID_write    (IFID_write),
    .IF_Flush      (IF_Flush),
    .EX_JumpOP     (EX_JumpOP),
    .EX_Jump_target(EX_Jump_target),
    .IM_instr      (IM_instr),
    .IM_addr       (IM_addr),
    .ID_Instr      (ID_Instr),
    .ID_PC         (ID_PC),
    .ID_PC_plus4   (ID_PC_plus4),
    .ID_Valid      (ID_Valid),
    .IF_stall_cnt  (IF_stall_cnt),
    .IF_flush_cnt  (IF_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] id_pc, input logic [31:0] id_p4, input logic vld);
    chk({tag, ".pc"}, IM_addr, pc);
    chk({tag, ".instr"}, ID_Instr, instr);
    chk({tag, ".id_pc"}, ID_PC, id_pc);
    chk({tag, ".id_pc4"}, ID_PC_plus4, id_p4);
    chk({tag, ".valid"}, {31'b0, ID_Valid}, {31'b0, vld});
  endtask

  task automatic chk_cnt(input string tag, input int stalls, input int flushes);
`ifdef IF_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, {16'b0, IF_stall_cnt}, 32'(stalls));
    chk({tag, ".flush_cnt"}, {16'b0, IF_flush_cnt}, 32'(flushes));
`else
    chk({tag, ".stall_cnt"}, {16'b0, IF_stall_cnt}, 32'(stalls * 0));
    chk({tag, ".flush_cnt"}, {16'b0, IF_flush_cnt}, 32'(flushes * 0));
`endif
  endtask

  initial begin
    rst = 1'b1; PC_write = 1'b0; IFID_write = 1'b0; IF_Flush = 1'b0;
    EX_JumpOP = 2'd0; EX_Jump_target = 32'h0;
    tick(); tick();
    chk_id("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("reset", 0, 0);

    rst = 1'b0;
    tick();
    chk_id("fetch0", 32'h4, 32'h2001_0005, 32'h0, 32'h4, 1'b1);
    tick();
    chk_id("fetch1", 32'h8, 32'hC000_0004, 32'h4, 32'h8, 1'b1);
    tick(); tick();
    chk_id("fetch3", 32'h10, 32'hC000_000C, 32'hC, 32'h10, 1'b1);

    // Two-cycle stall at PC=0x10.
    PC_write = 1'b1; IFID_write = 1'b1;
    tick(); tick();
    chk_id("stall", 32'h10, 32'hC000_000C, 32'hC, 32'h10, 1'b1);
    PC_write = 1'b0; IFID_write = 1'b0;
    tick();
    chk_id("release", 32'h14, 32'hC000_0010, 32'h10, 32'h14, 1'b1);
    tick(); tick(); tick();
    chk("pc_before_jump", IM_addr, 32'h20);

    // J at PC=0x20 to 0x400.
    IF_Flush = 1'b1; EX_JumpOP = 2'd1; EX_Jump_target = 32'h400;
    tick();
    chk_id("jump", 32'h400, 32'h0, 32'h0, 32'h0, 1'b0);
    IF_Flush = 1'b0; EX_JumpOP = 2'd0;
    tick();
    chk_id("jump_tgt", 32'h404, 32'hC000_0400, 32'h400, 32'h404, 1'b1);

    // Flush and stall together: flush wins, target low bits cleared.
    IF_Flush = 1'b1; PC_write = 1'b1; IFID_write = 1'b1; EX_JumpOP = 2'd2;
    EX_Jump_target = 32'h83;
    tick();
    chk_id("flush_stall", 32'h80, 32'h0, 32'h0, 32'h0, 1'b0);
    IF_Flush = 1'b0; PC_write = 1'b0; IFID_write = 1'b0; EX_JumpOP = 2'd0;
    tick();
    chk_id("jr_tgt", 32'h84, 32'hC000_0080, 32'h80, 32'h84, 1'b1);

    // Squash without redirect.
    IF_Flush = 1'b1;
    tick();
    chk_id("squash", 32'h88, 32'h0, 32'h0, 32'h0, 1'b0);
    IF_Flush = 1'b0;

    // PC held while IF/ID still captures.
    PC_write = 1'b1;
    tick();
    chk_id("pc_hold_only", 32'h88, 32'hC000_0088, 32'h88, 32'h8C, 1'b1);
    PC_write = 1'b0;

    // Branch to the top word, then wrap.
    IF_Flush = 1'b1; EX_JumpOP = 2'd3; EX_Jump_target = 32'hFFFF_FFFF;
    tick();
    chk("br_top.pc", IM_addr, 32'hFFFF_FFFC);
    IF_Flush = 1'b0; EX_JumpOP = 2'd0;
    tick();
    chk_id("wrap", 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
    chk_cnt("pre_rst", 3, 4);

    // Reset asserted in the middle of a stall.
    PC_write = 1'b1; IFID_write = 1'b1; rst = 1'b1;
    tick();
    chk_id("rst_mid", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("rst_mid", 0, 0);
    rst = 1'b0; PC_write = 1'b0; IFID_write = 1'b0;
    tick();
    chk_id("after_rst", 32'h4, 32'h2001_0005, 32'h0, 32'h4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
